// File: rtl/instr_encoder_if.sv
// instr_encoder_if
//   Handshake and field bundle between an instruction-word producer/consumer
//   and the RV32I encoder.
//   Input side : in_valid, in_ready, fmt, opcode, funct3, funct7, rs1, rs2,
//                rd, imm
//   Output side: out_valid, out_ready, instr, fmt_err, imm_err
//   master = bench/stimulus side, slave = encoder side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        fmt_err;
  logic        imm_err;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rs1, rs2, rd, imm, out_ready,
    input  in_ready, out_valid, instr, fmt_err, imm_err
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rs1, rs2, rd, imm, out_ready,
    output in_ready, out_valid, instr, fmt_err, imm_err
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder
//   Two-stage pipelined RV32I instruction encoder. S1 registers the field
//   bundle, S2 registers the packed word plus error flags. Full throughput,
//   no skid buffer: in_ready is combinational from out_ready.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - instr_encoder_if.slave (field bundle in, instruction word out)
// Parameters:
//   NOP_WORD - word emitted for an illegal format code
// Optional build macro:
//   INSTR_ENC_IMM_CHECK_EN - when defined, imm_err flags immediates that do
//   not fit their format; otherwise imm_err is tied low.
module instr_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  instr_encoder_if.slave bus
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic        s1_valid;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_opcode;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [4:0]  s1_rd;
  logic [31:0] s1_imm;

  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_fmt_err;

  logic        s2_load;
  logic        s1_load;
  logic [31:0] enc_word;
  logic        enc_fmt_err;

  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_fmt    <= bus.fmt;
        s1_opcode <= bus.opcode;
        s1_funct3 <= bus.funct3;
        s1_funct7 <= bus.funct7;
        s1_rs1    <= bus.rs1;
        s1_rs2    <= bus.rs2;
        s1_rd     <= bus.rd;
        s1_imm    <= bus.imm;
      end
    end
  end

  // Only the fields a format names are packed; everything else is dropped.
  always_comb begin
    enc_word    = NOP_WORD;
    enc_fmt_err = 1'b0;
    case (s1_fmt)
      FMT_R: enc_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_I: enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_S: enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      FMT_B: enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                         s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U: enc_word = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_J: enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                         s1_rd, s1_opcode};
      default: enc_fmt_err = 1'b1;
    endcase
  end

  // Word and flags only change when a real bundle moves in, so they hold
  // stable during a stall and keep their last value once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_instr   <= 32'h0;
      s2_fmt_err <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr   <= enc_word;
        s2_fmt_err <= enc_fmt_err;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.instr     = s2_instr;
  assign bus.fmt_err   = s2_fmt_err;

`ifdef INSTR_ENC_IMM_CHECK_EN
  logic enc_imm_err;
  logic s2_imm_err;

  // Sign-representability: every bit above the format's sign bit must
  // equal that sign bit.
  always_comb begin
    enc_imm_err = 1'b0;
    case (s1_fmt)
      FMT_I, FMT_S: enc_imm_err = (s1_imm[31:11] != {21{s1_imm[11]}});
      FMT_B:        enc_imm_err = (s1_imm[31:12] != {20{s1_imm[12]}}) || s1_imm[0];
      FMT_J:        enc_imm_err = (s1_imm[31:20] != {12{s1_imm[20]}}) || s1_imm[0];
      FMT_U:        enc_imm_err = (s1_imm[11:0] != 12'h000);
      default:      enc_imm_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_imm_err <= 1'b0;
    end else if (s2_load && s1_valid) begin
      s2_imm_err <= enc_imm_err;
    end
  end

  assign bus.imm_err = s2_imm_err;
`else
  assign bus.imm_err = 1'b0;
`endif

endmodule
